// File: rtl/vram_wr_arbiter.sv
// Round-robin arbiter sharing the text-mode VRAM write port between the command writer (port 0) and DMA (port 1).
// Optional build macro VRAM_WR_BLANK_ONLY_EN restricts new grants to blanking intervals.
module vram_wr_arbiter #(
  parameter int AW         = 12,
  parameter int DW         = 8,
  parameter int VRAM_DEPTH = 2000
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req0,
  input  logic          i_req1,
  input  logic [AW-1:0] i_adr0,
  input  logic [AW-1:0] i_adr1,
  input  logic [DW-1:0] i_data0,
  input  logic [DW-1:0] i_data1,
  output logic          o_ack0,
  output logic          o_ack1,
  input  logic          i_blank,
  output logic [AW-1:0] o_vram_adr,
  output logic [DW-1:0] o_vram_data,
  output logic          o_vram_we,
  output logic          o_err,
  output logic [15:0]   o_wr_cnt,
  output logic          o_busy
);

  typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;

  localparam logic [AW:0] DEPTH = (AW+1)'(VRAM_DEPTH);

  state_t        state_reg;
  logic          last_reg;
  logic          win_reg;
  logic [15:0]   wr_cnt_reg;
  logic          grant_ok;
  logic [1:0]    req_vec;
  logic [1:0]    eligible;
  logic          win_next;
  logic [AW-1:0] adr_sel;
  logic [DW-1:0] data_sel;
  logic          adr_ok;

`ifdef VRAM_WR_BLANK_ONLY_EN
  assign grant_ok = i_blank;
`else
  logic unused_blank;
  assign unused_blank = i_blank;
  assign grant_ok     = 1'b1;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign req_vec[gi]  = (gi == 0) ? i_req0 : i_req1;
      assign eligible[gi] = req_vec[gi] & grant_ok;
    end
  endgenerate

  // On a tie the port that did not win last time takes the grant.
  assign win_next = (eligible == 2'b11) ? ~last_reg : eligible[1];
  assign adr_sel  = win_next ? i_adr1  : i_adr0;
  assign data_sel = win_next ? i_data1 : i_data0;
  assign adr_ok   = ({1'b0, adr_sel} < DEPTH);
  assign o_wr_cnt = wr_cnt_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= 1'b1;
      win_reg     <= 1'b0;
      wr_cnt_reg  <= '0;
      o_vram_adr  <= '0;
      o_vram_data <= '0;
      o_vram_we   <= 1'b0;
      o_ack0      <= 1'b0;
      o_ack1      <= 1'b0;
      o_err       <= 1'b0;
      o_busy      <= 1'b0;
    end else begin
      o_ack0 <= 1'b0;
      o_ack1 <= 1'b0;
      o_err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (|eligible) begin
            state_reg   <= WRITE;
            last_reg    <= win_next;
            win_reg     <= win_next;
            o_vram_adr  <= adr_sel;
            o_vram_data <= data_sel;
            o_vram_we   <= adr_ok;
            o_busy      <= 1'b1;
          end
        end
        WRITE: begin
          // The strobe doubles as the in-range flag for the latched address.
          o_vram_we <= 1'b0;
          o_ack0    <= ~win_reg;
          o_ack1    <= win_reg;
          o_err     <= ~o_vram_we;
          if (o_vram_we) wr_cnt_reg <= wr_cnt_reg + 16'd1;
          state_reg <= ACK;
        end
        ACK: begin
          state_reg <= IDLE;
          o_busy    <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          o_vram_we <= 1'b0;
          o_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter: a transaction-level timeline model checked every cycle,
// plus hand-computed expectations for latency, arbitration order, range errors and counter wrap.
module tb_vram_wr_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int DEPTH = 2000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0 = 1'b0, req1 = 1'b0, blank = 1'b0;
  logic [AW-1:0] adr0 = '0, adr1 = '0;
  logic [DW-1:0] data0 = '0, data1 = '0;
  logic          ack0, ack1, vram_we, err, busy;
  logic [AW-1:0] vram_adr;
  logic [DW-1:0] vram_data;
  logic [15:0]   wr_cnt;

  int errors = 0;
  int checks = 0;

  vram_wr_arbiter #(.AW(AW), .DW(DW), .VRAM_DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_req1(req1),
    .i_adr0(adr0), .i_adr1(adr1),
    .i_data0(data0), .i_data1(data1),
    .o_ack0(ack0), .o_ack1(ack1),
    .i_blank(blank),
    .o_vram_adr(vram_adr), .o_vram_data(vram_data), .o_vram_we(vram_we),
    .o_err(err), .o_wr_cnt(wr_cnt), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a granted transaction occupies three cycles (write, ack, recovery).
  int            m_phase;
  bit            m_last, m_win, m_ok;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_data;
  bit            m_we, m_ack0, m_ack1, m_err, m_busy;
  logic [15:0]   m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_last = 1'b1; m_win = 1'b0; m_ok = 1'b0;
      m_adr = '0; m_data = '0; m_we = 0; m_ack0 = 0; m_ack1 = 0;
      m_err = 0; m_busy = 0; m_cnt = '0;
    end else begin
      case (m_phase)
        0: begin
          bit elig0, elig1;
          elig0 = req0;
          elig1 = req1;
`ifdef VRAM_WR_BLANK_ONLY_EN
          elig0 = elig0 && blank;
          elig1 = elig1 && blank;
`endif
          if (elig0 || elig1) begin
            if (elig0 && elig1) m_win = !m_last;
            else m_win = elig1;
            m_last = m_win;
            m_adr  = m_win ? adr1 : adr0;
            m_data = m_win ? data1 : data0;
            m_ok   = (int'(m_adr) < DEPTH);
            m_we   = m_ok;
            m_busy = 1;
            m_phase = 1;
          end
        end
        1: begin
          m_we = 0;
          m_ack0 = !m_win;
          m_ack1 = m_win;
          m_err = !m_ok;
          if (m_ok) m_cnt = m_cnt + 16'd1;
          m_phase = 2;
        end
        default: begin
          m_ack0 = 0; m_ack1 = 0; m_err = 0; m_busy = 0;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    check("we", vram_we, m_we);
    check("adr", vram_adr, m_adr);
    check("data", vram_data, m_data);
    check("ack0", ack0, m_ack0);
    check("ack1", ack1, m_ack1);
    check("err", err, m_err);
    check("cnt", wr_cnt, m_cnt);
    check("busy", busy, m_busy);
  end

  task automatic wait_ack(input bit port, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(port ? ack1 : ack0) && n < 20);
    check({name, "_ack"}, port ? ack1 : ack0, 1);
  endtask

  task automatic do_write(input bit port, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input string name);
    @(negedge clk);
    if (port) begin req1 = 1; adr1 = a; data1 = d; end
    else begin req0 = 1; adr0 = a; data0 = d; end
    wait_ack(port, name);
    if (port) req1 = 0; else req0 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit        got[$];
    int        wes[$];
    int        n;

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_we", vram_we, 0);
    check("rst_cnt", wr_cnt, 0);
    check("rst_busy", busy, 0);
    check("rst_adr", vram_adr, 0);
    rst_n = 1;

    // Single write on port 0: strobe one cycle after grant edge, ack one later
    @(negedge clk);
    req0 = 1; adr0 = 12'h000; data0 = 8'h41;
    @(negedge clk);
    check("t1_we", vram_we, 1);
    check("t1_adr", vram_adr, 12'h000);
    check("t1_data", vram_data, 8'h41);
    check("t1_ack_early", ack0, 0);
    @(negedge clk);
    check("t1_ack", ack0, 1);
    check("t1_cnt", wr_cnt, 16'd1);
    req0 = 0;
    @(negedge clk);
    check("t1_idle", busy, 0);

    // Out-of-range address on port 1
    do_write(1, 12'h7D0, 8'h55, "oor");
    check("oor_err", err, 1);
    check("oor_cnt", wr_cnt, 16'd1);

    // Last valid address
    do_write(1, 12'd1999, 8'h66, "last");
    check("last_err", err, 0);
    check("last_cnt", wr_cnt, 16'd2);

    // Both requesting continuously: alternating grants 3 clocks apart
    @(negedge clk);
    req0 = 1; adr0 = 12'd10; data0 = 8'hA0;
    req1 = 1; adr1 = 12'd20; data1 = 8'hB1;
    n = 0;
    while (got.size() < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (vram_we) wes.push_back(n);
      if (ack0 || ack1) got.push_back(ack1);
    end
    req0 = 0; req1 = 0;
    check("tie_acks", got.size(), 4);
    check("tie_wes", wes.size(), 4);
    if (got.size() == 4) begin
      check("tie_g0", got[0], 0);
      check("tie_g1", got[1], 1);
      check("tie_g2", got[2], 0);
      check("tie_g3", got[3], 1);
    end
    for (int i = 1; i < wes.size(); i++) check("tie_space", wes[i] - wes[i-1], 3);
    check("tie_cnt", wr_cnt, 16'd6);

    // Counter wrap
    @(posedge clk);
    #2;
    force dut.wr_cnt_reg = 16'hFFFF;
    m_cnt = 16'hFFFF;
    @(posedge clk);
    #2;
    release dut.wr_cnt_reg;
    do_write(0, 12'd5, 8'h11, "wrap");
    check("wrap_cnt", wr_cnt, 16'h0000);

    // Reset during WRITE aborts the transaction
    @(negedge clk);
    req1 = 1; adr1 = 12'd30; data1 = 8'h33;
    @(negedge clk);
    check("abort_we_pre", vram_we, 1);
    #2 rst_n = 0;
    #1;
    check("abort_we", vram_we, 0);
    check("abort_busy", busy, 0);
    req1 = 0;
    repeat (2) begin
      @(negedge clk);
      check("abort_noack", ack1, 0);
    end
    rst_n = 1;

    // After reset a tie goes to port 0
    @(negedge clk);
    req0 = 1; adr0 = 12'd40; data0 = 8'h44;
    req1 = 1; adr1 = 12'd50; data1 = 8'h55;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack0 || ack1) && n < 20);
    check("post_rst_ack0", ack0, 1);
    check("post_rst_ack1", ack1, 0);
    req0 = 0; req1 = 0;

`ifdef VRAM_WR_BLANK_ONLY_EN
    // Grants wait for blanking; a granted write survives blank falling
    @(negedge clk);
    blank = 0; req0 = 1; adr0 = 12'd7; data0 = 8'h77;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("blank_hold", n, 0);
    blank = 1;
    @(negedge clk);
    check("blank_we", vram_we, 1);
    blank = 0;
    wait_ack(0, "blank");
    req0 = 0;
`else
    // Blank level has no effect on granting
    @(negedge clk);
    blank = 0;
    do_write(0, 12'd7, 8'h77, "noblank");
    check("noblank_adr", vram_adr, 12'd7);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
